mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter sharing one memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between the pipeline's fetch/memory stages and the single memory slave. It serialises one transaction at a time over valid/ready request and response channels, and breaks ties round-robin.

## Interface
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width; write mask width is `DATA_W/8`.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `ifu_req_valid` in 1, `ifu_req_ready` out 1, `ifu_req_addr` in `ADDR_W`: IFU read request.
- `ifu_resp_valid` out 1, `ifu_resp_ready` in 1, `ifu_resp_data` out `DATA_W`: IFU response.
- `lsu_req_valid` in 1, `lsu_req_ready` out 1, `lsu_req_addr` in `ADDR_W`: LSU request.
- `lsu_req_wen` in 1, `lsu_req_wdata` in `DATA_W`, `lsu_req_wmask` in `DATA_W/8`: LSU request, write fields.
- `lsu_resp_valid` out 1, `lsu_resp_ready` in 1, `lsu_resp_data` out `DATA_W`: LSU response.
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory request handshake.
- `mem_req_addr` out `ADDR_W`, `mem_req_wen` out 1, `mem_req_wdata` out `DATA_W`, `mem_req_wmask` out `DATA_W/8`: memory request payload.
- `mem_resp_valid` in 1, `mem_resp_ready` out 1, `mem_resp_data` in `DATA_W`: memory response.

## Operation
- States: IDLE, REQ, RESP. Registers: `state`, `owner` (IFU/LSU), `last_owner`, latched `addr`/`wen`/`wdata`/`wmask`.
- **IDLE**
  - Grant: only one requester valid → that one. Both valid → the one that is not `last_owner`.
  - Granted requester's `*_req_ready` = 1 (combinational). The other requester's ready = 0.
  - On handshake: latch the payload and set `owner`. For IFU, latched `wen`=0, `wdata`=0, `wmask`=0. Next state REQ.
- **REQ**
  - `mem_req_valid`=1, payload driven from the latched registers and held stable.
  - On `mem_req_ready` → RESP.
- **RESP**
  - `mem_resp_ready` = `owner`'s `*_resp_ready`.
  - `owner`'s `*_resp_valid` = `mem_resp_valid`. The other requester's resp_valid = 0.
  - On the response handshake: `last_owner` ← `owner`, next state IDLE.
  - Writes also complete with a response; its data is don't-care.
- `ifu_resp_data` and `lsu_resp_data` both equal `mem_resp_data` combinationally. Only the valids are gated.
- Outside RESP: `mem_resp_ready`=0, and a stray `mem_resp_valid` is ignored.
- Requesters may drop valid before they are granted; nothing is latched in that case.
- All `*_req_ready` = 0 outside IDLE.

## Timing
- Reset values:
  - `state`=IDLE, `last_owner`=IFU (so LSU wins the first tie), latched payload = 0.
  - Outputs: every valid/ready output = 0, `mem_req_*` = 0, resp_data follows `mem_resp_data`.
- Latency, with the request accepted at cycle 0:
  - `mem_req_valid` is high from cycle 1.
  - With `mem_req_ready` already high: RESP at cycle 2, earliest response handshake at cycle 2.
  - Back in IDLE at cycle 3.
- Minimum throughput: one transaction per 3 cycles.
- `mem_req_ready` stalls hold REQ indefinitely with the payload constant. Response stalls on either side hold RESP.
- Reset asserted mid-transaction: immediate return to IDLE and the outstanding transaction is dropped. The memory slave shares `rst`.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` enum {IDLE, REQ, RESP}.
  - `owner_t` enum {OWN_IFU, OWN_LSU}.
  - Reset constant for `last_owner`.
- One natural sub-module `rr_pick2`: combinational two-way round-robin picker with inputs (req0, req1, last) and outputs (gnt0, gnt1). Everything else lives in `mem_arbiter`.
- Target size is roughly 150–250 lines of RTL.

## Test plan
- **IFU-only read.** `ifu_req_addr`=0x8000_0000, memory ready immediately and returns 0x0000_0413.
  - `ifu_req_ready` is high at cycle 0 and `mem_req_addr`=0x8000_0000 at cycle 1.
  - `ifu_resp_data`=0x0000_0413 with `ifu_resp_valid` at cycle 2.
  - `lsu_resp_valid` never rises.
- **Tie after reset.** Both request in the same cycle.
  - LSU is granted first. IFU is granted on the next IDLE entry.
  - A second tie is then won by LSU again, since `last_owner`=IFU.
- **LSU write.** addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 0xF, wen=1.
  - `mem_req_*` carries exactly those values.
  - The response is delivered on `lsu_resp_valid` and the state returns to IDLE.
- **Backpressure.** Hold `mem_req_ready`=0 for 5 cycles, then hold `lsu_resp_ready`=0 for 3 cycles.
  - The payload stays stable through both stalls.
  - `mem_resp_ready` mirrors `lsu_resp_ready`.
  - No new grants are issued while stalled.
- **Reset in RESP.** Assert `rst` while in RESP.
  - All outputs go to 0 asynchronously.
  - After release, a new IFU request is accepted normally.
- **Stray response.** Pulse `mem_resp_valid` in IDLE.
  - `ifu_resp_valid` and `lsu_resp_valid` both stay 0.
  - `mem_resp_ready` stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
//   state_t      : arbiter FSM states (IDLE -> REQ -> RESP -> IDLE)
//   owner_t      : which requester owns the in-flight transaction
//   LastOwnerRst : reset value of last_owner; IFU so that LSU wins the first tie
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_t;

  localparam owner_t LastOwnerRst = OWN_IFU;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
//   req0, req1 : request lines
//   last       : 0 = requester 0 was served last, 1 = requester 1 was served last
//   gnt0, gnt1 : one-hot (or zero) grant; on a tie the requester not served last wins
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = req0 & (~req1 | last);
    gnt1 = req1 & (~req0 | ~last);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction fetch unit (read-only) and the
// load/store unit (read/write). One transaction is in flight at a time; ties are
// broken round-robin against the previous owner.
//   clk, rst            : clock, asynchronous active-high reset
//   ifu_req_*           : IFU read request (valid/ready, addr)
//   ifu_resp_*          : IFU response (valid/ready, data)
//   lsu_req_*           : LSU request (valid/ready, addr, wen, wdata, wmask)
//   lsu_resp_*          : LSU response (valid/ready, data)
//   mem_req_*           : request to the memory slave, payload held from latched copy
//   mem_resp_*          : response from the memory slave
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_data,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_data,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  localparam int unsigned MaskW = DATA_W / 8;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MaskW-1:0]    wmask_q, wmask_d;

  logic gnt_ifu, gnt_lsu;

  rr_pick2 u_pick (
    .req0 (ifu_req_valid),
    .req1 (lsu_req_valid),
    .last (last_owner_q == OWN_LSU),
    .gnt0 (gnt_ifu),
    .gnt1 (gnt_lsu)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        // rst gating keeps every ready low while reset is held, even with a
        // requester asserting valid against the (already reset) IDLE state.
        ifu_req_ready = gnt_ifu & ~rst;
        lsu_req_ready = gnt_lsu & ~rst;
        if (gnt_lsu) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          state_d = REQ;
        end else if (gnt_ifu) begin
          owner_d = OWN_IFU;
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (owner_q == OWN_LSU) begin
          mem_resp_ready = lsu_resp_ready;
          lsu_resp_valid = mem_resp_valid;
        end else begin
          mem_resp_ready = ifu_resp_ready;
          ifu_resp_valid = mem_resp_valid;
        end
        if (mem_resp_valid && mem_resp_ready) begin
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_owner_q <= LastOwnerRst;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Payload comes straight from the latched copy so it stays stable across stalls.
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  // Data is broadcast; only the valids are steered to the owner.
  assign ifu_resp_data = mem_resp_data;
  assign lsu_resp_data = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_resp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_resp_data  (ifu_resp_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wmask  (lsu_req_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_resp_data  (lsu_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid  = 1'b0;
    ifu_req_addr   = '0;
    ifu_resp_ready = 1'b1;
    lsu_req_valid  = 1'b0;
    lsu_req_addr   = '0;
    lsu_req_wen    = 1'b0;
    lsu_req_wdata  = '0;
    lsu_req_wmask  = '0;
    lsu_resp_ready = 1'b1;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  // Entered in the REQ cycle; completes the memory side and returns in IDLE.
  task automatic serve(input logic [31:0] d);
    mem_req_ready = 1'b1;
    cycle();
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    cycle();
    mem_resp_valid = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic test_reset();
    logic [5:0] vr;
    rst = 1'b1;
    idle_inputs();
    ifu_req_valid  = 1'b1;
    lsu_req_valid  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    #3;
    vr = {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid,
          lsu_resp_valid};
    n_checks++;
    if (vr !== 6'b0) begin
      n_fail++; $display("FAIL reset_handshakes: got %b want 000000", vr);
    end
    n_checks++;
    if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== 69'd0) begin
      n_fail++; $display("FAIL reset_payload: got addr %h wen %b wdata %h wmask %h want 0",
                         mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
    end
    n_checks++;
    if (ifu_resp_data !== 32'h1234_5678 || lsu_resp_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL reset_resp_data: got %h/%h want 12345678",
                         ifu_resp_data, lsu_resp_data);
    end
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
  endtask

  task automatic test_ifu_only();
    idle_inputs();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL ifu_c0: got ready %b/%b mreqv %b want 1/0/0",
                         ifu_req_ready, lsu_req_ready, mem_req_valid);
    end
    cycle();
    ifu_req_valid = 1'b0;
    ifu_req_addr  = 32'h0BAD_0BAD;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_wen !== 1'b0 ||
        mem_req_wdata !== 32'h0 || mem_req_wmask !== 4'h0) begin
      n_fail++; $display("FAIL ifu_c1: got v %b addr %h wen %b wd %h wm %h want 1 80000000 0 0 0",
                         mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
                         mem_req_wmask);
    end
    cycle();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0413;
    #1;
    n_checks++;
    if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h0000_0413 ||
        lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
      n_fail++; $display("FAIL ifu_c2: got rv %b data %h lrv %b mrr %b want 1 00000413 0 1",
                         ifu_resp_valid, ifu_resp_data, lsu_resp_valid, mem_resp_ready);
    end
    cycle();
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b1;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1 || mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL ifu_c3_idle: got rdy %b mreqv %b rv %b want 1 0 0",
                         ifu_req_ready, mem_req_valid, ifu_resp_valid);
    end
    // Drop valid before the edge: nothing may be launched.
    ifu_req_valid = 1'b0;
    cycle();
    n_checks++;
    if (mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL ifu_dropped_valid: got mreqv %b want 0", mem_req_valid);
    end
  endtask

  task automatic test_tie();
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h100;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h200;
    #1;
    n_checks++;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL tie_first: got lsu %b ifu %b want 1 0",
                         lsu_req_ready, ifu_req_ready);
    end
    cycle();
    lsu_req_valid = 1'b0;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b0 || mem_req_addr !== 32'h200) begin
      n_fail++; $display("FAIL tie_req1: got ifu_rdy %b addr %h want 0 00000200",
                         ifu_req_ready, mem_req_addr);
    end
    serve(32'hAAAA_0001);
    lsu_req_valid = 1'b1;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL tie_second: got ifu %b lsu %b want 1 0",
                         ifu_req_ready, lsu_req_ready);
    end
    cycle();
    ifu_req_valid = 1'b0;
    #1;
    n_checks++;
    if (mem_req_addr !== 32'h100) begin
      n_fail++; $display("FAIL tie_req2: got addr %h want 00000100", mem_req_addr);
    end
    serve(32'hAAAA_0002);
    ifu_req_valid = 1'b1;
    #1;
    n_checks++;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL tie_third: got lsu %b ifu %b want 1 0",
                         lsu_req_ready, ifu_req_ready);
    end
    cycle();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    serve(32'hAAAA_0003);
  endtask

  task automatic test_lsu_write();
    idle_inputs();
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h8000_0010;
    lsu_req_wen   = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF;
    lsu_req_wmask = 4'hF;
    #1;
    n_checks++;
    if (lsu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_ready: got %b want 1", lsu_req_ready);
    end
    cycle();
    lsu_req_valid = 1'b0;
    lsu_req_addr  = 32'h1111_1111;
    lsu_req_wen   = 1'b0;
    lsu_req_wdata = 32'h2222_2222;
    lsu_req_wmask = 4'h3;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010 || mem_req_wen !== 1'b1 ||
        mem_req_wdata !== 32'hDEAD_BEEF || mem_req_wmask !== 4'hF) begin
      n_fail++; $display("FAIL wr_payload: got v %b addr %h wen %b wd %h wm %h want 1 80000010 1 deadbeef f",
                         mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
                         mem_req_wmask);
    end
    cycle();
    mem_resp_valid = 1'b1;
    #1;
    n_checks++;
    if (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_resp: got lsu %b ifu %b want 1 0",
                         lsu_resp_valid, ifu_resp_valid);
    end
    cycle();
    mem_resp_valid = 1'b0;
    lsu_req_valid  = 1'b1;
    #1;
    n_checks++;
    if (lsu_req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_back_idle: got rdy %b mreqv %b want 1 0",
                         lsu_req_ready, mem_req_valid);
    end
    lsu_req_valid = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h300;
    cycle();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h400;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300 || mem_req_wen !== 1'b0 ||
          ifu_req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_req_stall[%0d]: got v %b addr %h wen %b ifu_rdy %b want 1 300 0 0",
                           i, mem_req_valid, mem_req_addr, mem_req_wen, ifu_req_ready);
      end
      cycle();
    end
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready  = 1'b0;
    lsu_resp_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h5555_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (mem_resp_ready !== 1'b0 || lsu_resp_valid !== 1'b1 || ifu_req_ready !== 1'b0 ||
          mem_req_valid !== 1'b0 || mem_req_addr !== 32'h300) begin
        n_fail++; $display("FAIL bp_resp_stall[%0d]: got mrr %b lrv %b ifu_rdy %b mreqv %b addr %h want 0 1 0 0 300",
                           i, mem_resp_ready, lsu_resp_valid, ifu_req_ready, mem_req_valid,
                           mem_req_addr);
      end
      cycle();
    end
    lsu_resp_ready = 1'b1;
    #1;
    n_checks++;
    if (mem_resp_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_mirror: got mrr %b want 1", mem_resp_ready);
    end
    cycle();
    mem_resp_valid = 1'b0;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_next_grant: got ifu_rdy %b want 1", ifu_req_ready);
    end
    cycle();
    ifu_req_valid = 1'b0;
    serve(32'h0);
  endtask

  task automatic test_reset_in_resp();
    logic [5:0] vr;
    idle_inputs();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h500;
    cycle();
    ifu_req_valid = 1'b0;
    cycle();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h5050_5050;
    ifu_resp_ready = 1'b0;
    #1;
    n_checks++;
    if (ifu_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL rr_in_resp: got ifu_rv %b want 1", ifu_resp_valid);
    end
    ifu_req_valid = 1'b1;
    rst = 1'b1;
    #1;
    vr = {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid,
          lsu_resp_valid};
    n_checks++;
    if (vr !== 6'b0 || mem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL rr_async_clear: got %b addr %h want 000000 0", vr, mem_req_addr);
    end
    rst = 1'b0;
    ifu_req_valid  = 1'b0;
    mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b1;
    cycle();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h600;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rr_after_release: got ifu_rdy %b want 1", ifu_req_ready);
    end
    cycle();
    ifu_req_valid = 1'b0;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h600) begin
      n_fail++; $display("FAIL rr_new_req: got v %b addr %h want 1 00000600",
                         mem_req_valid, mem_req_addr);
    end
    serve(32'h6666_6666);
  endtask

  task automatic test_stray();
    idle_inputs();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h7777_7777;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b0) begin
        n_fail++; $display("FAIL stray_idle[%0d]: got %b %b %b want 0 0 0",
                           i, ifu_resp_valid, lsu_resp_valid, mem_resp_ready);
      end
      cycle();
    end
    mem_resp_valid = 1'b0;
    lsu_req_valid  = 1'b1;
    lsu_req_addr   = 32'h700;
    cycle();
    lsu_req_valid  = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    n_checks++;
    if (lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b0 || mem_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL stray_req: got lrv %b mrr %b mreqv %b want 0 0 1",
                         lsu_resp_valid, mem_resp_ready, mem_req_valid);
    end
    cycle();
    mem_resp_valid = 1'b0;
    serve(32'h0);
  endtask

  // Randomised traffic against a transaction-level model of the arbiter and a memory.
  task automatic test_random();
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    int          phase;  // 0 idle, 1 request issued, 2 awaiting response
    bit          own_lsu, last_lsu, ifu_have, lsu_have, slv_pend;
    logic [31:0] ifu_a, lsu_a, lsu_wd, cur_a, cur_wd, exp_rdata, slv_data;
    logic [3:0]  lsu_wm, cur_wm;
    bit          lsu_we, cur_we;
    bit e_ifu_rdy, e_lsu_rdy, e_mrr, e_ifu_rv, e_lsu_rv;

    idle_inputs();
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = $urandom;
      slv_mem[k] = ref_mem[k];
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    cycle();
    phase = 0; own_lsu = 0; last_lsu = 0; ifu_have = 0; lsu_have = 0; slv_pend = 0;
    cur_a = '0; cur_wd = '0; cur_wm = '0; cur_we = 0; exp_rdata = '0; slv_data = '0;
    ifu_a = '0; lsu_a = '0; lsu_wd = '0; lsu_wm = '0; lsu_we = 0;

    for (int c = 0; c < 600; c++) begin
      if (!ifu_have && ($urandom % 3 == 0)) begin
        ifu_have = 1; ifu_a = 32'h1000 + ($urandom % 16) * 4;
      end
      if (!lsu_have && ($urandom % 3 == 0)) begin
        lsu_have = 1; lsu_a = 32'h1000 + ($urandom % 16) * 4;
        lsu_we = $urandom % 2; lsu_wd = $urandom; lsu_wm = 4'($urandom % 16);
      end
      ifu_req_valid  = ifu_have && ($urandom % 4 != 0);
      ifu_req_addr   = ifu_a;
      lsu_req_valid  = lsu_have && ($urandom % 4 != 0);
      lsu_req_addr   = lsu_a;
      lsu_req_wen    = lsu_we;
      lsu_req_wdata  = lsu_wd;
      lsu_req_wmask  = lsu_wm;
      ifu_resp_ready = ($urandom % 4 != 0);
      lsu_resp_ready = ($urandom % 4 != 0);
      mem_req_ready  = ($urandom % 3 != 0);
      if (slv_pend) begin
        mem_resp_valid = ($urandom % 3 != 0);
        mem_resp_data  = mem_resp_valid ? slv_data : $urandom;
      end else begin
        mem_resp_valid = ($urandom % 5 == 0);
        mem_resp_data  = $urandom;
      end
      #2;

      e_ifu_rdy = (phase == 0) && ifu_req_valid && (!lsu_req_valid || last_lsu);
      e_lsu_rdy = (phase == 0) && lsu_req_valid && (!ifu_req_valid || !last_lsu);
      e_mrr     = (phase == 2) && (own_lsu ? lsu_resp_ready : ifu_resp_ready);
      e_ifu_rv  = (phase == 2) && !own_lsu && mem_resp_valid;
      e_lsu_rv  = (phase == 2) && own_lsu && mem_resp_valid;

      n_checks++;
      if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid,
           lsu_resp_valid} !== {e_ifu_rdy, e_lsu_rdy, (phase == 1), e_mrr, e_ifu_rv, e_lsu_rv})
      begin
        n_fail++; $display("FAIL rnd_ctrl[%0d]: got %b%b%b%b%b%b want %b%b%b%b%b%b", c,
                           ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready,
                           ifu_resp_valid, lsu_resp_valid, e_ifu_rdy, e_lsu_rdy, (phase == 1),
                           e_mrr, e_ifu_rv, e_lsu_rv);
      end
      n_checks++;
      if (ifu_resp_data !== mem_resp_data || lsu_resp_data !== mem_resp_data) begin
        n_fail++; $display("FAIL rnd_passthru[%0d]: got %h/%h want %h", c, ifu_resp_data,
                           lsu_resp_data, mem_resp_data);
      end
      if (phase == 1) begin
        n_checks++;
        if (mem_req_addr !== cur_a || mem_req_wen !== cur_we || mem_req_wdata !== cur_wd ||
            mem_req_wmask !== cur_wm) begin
          n_fail++; $display("FAIL rnd_payload[%0d]: got %h %b %h %h want %h %b %h %h", c,
                             mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
                             cur_a, cur_we, cur_wd, cur_wm);
        end
      end
      if (phase == 2 && mem_resp_valid && e_mrr && !cur_we) begin
        n_checks++;
        if ((own_lsu ? lsu_resp_data : ifu_resp_data) !== exp_rdata) begin
          n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c,
                             own_lsu ? lsu_resp_data : ifu_resp_data, exp_rdata);
        end
      end

      // Memory slave reacts to what the DUT actually presents.
      if (mem_req_valid && mem_req_ready) begin
        slv_pend = 1;
        slv_data = slv_mem[mem_req_addr[5:2]];
        if (mem_req_wen)
          slv_mem[mem_req_addr[5:2]] = merge(slv_mem[mem_req_addr[5:2]], mem_req_wdata,
                                             mem_req_wmask);
      end else if (mem_resp_valid && mem_resp_ready) begin
        slv_pend = 0;
      end

      // Reference model advance.
      if (phase == 0) begin
        if (e_lsu_rdy) begin
          own_lsu = 1; lsu_have = 0; phase = 1;
          cur_a = lsu_a; cur_we = lsu_we;
          cur_wd = lsu_we ? lsu_wd : 32'h0;
          cur_wm = lsu_we ? lsu_wm : 4'h0;
          cur_wd = lsu_wd; cur_wm = lsu_wm;
          exp_rdata = ref_mem[lsu_a[5:2]];
          if (lsu_we) ref_mem[lsu_a[5:2]] = merge(ref_mem[lsu_a[5:2]], lsu_wd, lsu_wm);
        end else if (e_ifu_rdy) begin
          own_lsu = 0; ifu_have = 0; phase = 1;
          cur_a = ifu_a; cur_we = 0; cur_wd = '0; cur_wm = '0;
          exp_rdata = ref_mem[ifu_a[5:2]];
        end
      end else if (phase == 1) begin
        if (mem_req_ready) phase = 2;
      end else begin
        if (mem_resp_valid && e_mrr) begin
          phase = 0; last_lsu = own_lsu;
        end
      end
      cycle();
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    test_reset();
    test_ifu_only();
    test_tie();
    test_lsu_write();
    test_backpressure();
    test_reset_in_resp();
    test_stray();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
